// File: rtl/prf_write_sequencer.sv
// Write-side sequencer for a single-port PRF: request FIFO plus registered write port.
// Define PRF_WSEQ_INIT_SWEEP_EN to zero every PRF entry after reset.
module prf_write_sequencer #(
    parameter int WORD_COUNT = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic                          REQ_VALID,
    output logic                          REQ_READY,
    input  logic [$clog2(WORD_COUNT)-1:0] REQ_ADDR,
    input  logic [31:0]                   REQ_DATA,
    input  logic [31:0]                   REQ_MASK,
    output logic                          WEC,
    output logic [31:0]                   BWC,
    output logic [31:0]                   DC,
    output logic [$clog2(WORD_COUNT)-1:0] AC,
    output logic                          INIT_DONE,
    output logic [$clog2(FIFO_DEPTH):0]   PENDING
);

    localparam int AW = $clog2(WORD_COUNT);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] fa [FIFO_DEPTH];
    logic [31:0]   fd [FIFO_DEPTH];
    logic [31:0]   fm [FIFO_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   cnt;
    logic          push;
    logic          pop;

`ifdef PRF_WSEQ_INIT_SWEEP_EN
    logic [AW-1:0] sweep;
`endif

    // Readiness looks only at current occupancy, never at a same-cycle pop
    assign REQ_READY = INIT_DONE && (cnt < (PW+1)'(FIFO_DEPTH));
    assign push      = REQ_VALID && REQ_READY;
    assign pop       = (cnt != '0);
    assign PENDING   = cnt;

    always_ff @(posedge CLK) begin
        if (push) begin
            fa[wp] <= REQ_ADDR;
            fd[wp] <= REQ_DATA;
            fm[wp] <= REQ_MASK;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= S_INIT;
            INIT_DONE <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            WEC       <= 1'b1;
            BWC       <= '1;
            DC        <= '0;
            AC        <= '0;
`ifdef PRF_WSEQ_INIT_SWEEP_EN
            sweep     <= '0;
`endif
        end else begin
            unique case (state)
                S_INIT: begin
`ifdef PRF_WSEQ_INIT_SWEEP_EN
                    WEC   <= 1'b0;
                    BWC   <= '0;
                    DC    <= '0;
                    AC    <= sweep;
                    sweep <= sweep + 1'b1;
                    if (sweep == AW'(WORD_COUNT - 1)) begin
                        state <= S_RUN;
                    end
`else
                    state     <= S_RUN;
                    INIT_DONE <= 1'b1;
`endif
                end
                S_RUN: begin
                    INIT_DONE <= 1'b1;
                    if (pop) begin
                        // An all-zero mask still consumes the entry but issues no write
                        WEC <= ~|fm[rp];
                        BWC <= ~fm[rp];
                        DC  <= fd[rp];
                        AC  <= fa[rp];
                        rp  <= rp + 1'b1;
                    end else begin
                        WEC <= 1'b1;
                        BWC <= '1;
                    end
                    if (push) begin
                        wp <= wp + 1'b1;
                    end
                    cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_prf_write_sequencer.sv
// Directed bench for prf_write_sequencer with a behavioural PRF on its write port.
// Expectations follow PRF_WSEQ_INIT_SWEEP_EN when it is visible to this file.
module tb_prf_write_sequencer;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [4:0]  REQ_ADDR = '0;
    logic [31:0] REQ_DATA = '0;
    logic [31:0] REQ_MASK = '0;
    logic        WEC;
    logic [31:0] BWC;
    logic [31:0] DC;
    logic [4:0]  AC;
    logic        INIT_DONE;
    logic [2:0]  PENDING;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] prf [32];
    logic [31:0] old;

    prf_write_sequencer #(.WORD_COUNT(32), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_MASK(REQ_MASK),
        .WEC(WEC), .BWC(BWC), .DC(DC), .AC(AC),
        .INIT_DONE(INIT_DONE), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    // PRF array: bit written where BWC is low, on posedge with WEC low
    always @(posedge CLK) begin
        if (RESETN && !WEC) begin
            prf[AC] <= (prf[AC] & BWC) | (DC & ~BWC);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push1(input logic [4:0] a, input logic [31:0] d, input logic [31:0] m);
        REQ_VALID = 1'b1;
        REQ_ADDR  = a;
        REQ_DATA  = d;
        REQ_MASK  = m;
        chk("push_ready", {31'd0, REQ_READY}, 32'd1);
        tick();
        REQ_VALID = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wec"}, {31'd0, WEC}, 32'd1);
        chk({tag, "_bwc"}, BWC, 32'hFFFF_FFFF);
        chk({tag, "_dc"}, DC, 32'd0);
        chk({tag, "_ac"}, {27'd0, AC}, 32'd0);
        chk({tag, "_ready"}, {31'd0, REQ_READY}, 32'd0);
        chk({tag, "_done"}, {31'd0, INIT_DONE}, 32'd0);
        chk({tag, "_pend"}, {29'd0, PENDING}, 32'd0);
    endtask

    task automatic run_init();
        @(negedge CLK);
        RESETN = 1'b1;
`ifdef PRF_WSEQ_INIT_SWEEP_EN
        for (int i = 0; i < 32; i++) begin
            tick();
            chk($sformatf("sweep_wec%0d", i), {31'd0, WEC}, 32'd0);
            chk($sformatf("sweep_ac%0d", i), {27'd0, AC}, i);
            chk($sformatf("sweep_dc%0d", i), DC, 32'd0);
            chk($sformatf("sweep_bwc%0d", i), BWC, 32'd0);
            chk($sformatf("sweep_done%0d", i), {31'd0, INIT_DONE}, 32'd0);
            chk($sformatf("sweep_rdy%0d", i), {31'd0, REQ_READY}, 32'd0);
        end
`endif
        tick();
        chk("init_done", {31'd0, INIT_DONE}, 32'd1);
        chk("init_ready", {31'd0, REQ_READY}, 32'd1);
        chk("init_wec_idle", {31'd0, WEC}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_vals("rst");

        run_init();
`ifdef PRF_WSEQ_INIT_SWEEP_EN
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("prf_zero%0d", i), prf[i], 32'd0);
        end
`endif

        // single full-mask write
        push1(5'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        chk("single_pend1", {29'd0, PENDING}, 32'd1);
        chk("single_wec_e", {31'd0, WEC}, 32'd1);
        tick();
        chk("single_wec", {31'd0, WEC}, 32'd0);
        chk("single_ac", {27'd0, AC}, 32'd5);
        chk("single_dc", DC, 32'hDEAD_BEEF);
        chk("single_bwc", BWC, 32'd0);
        chk("single_pend0", {29'd0, PENDING}, 32'd0);
        tick();
        chk("single_prf", prf[5], 32'hDEAD_BEEF);
        chk("idle_wec", {31'd0, WEC}, 32'd1);
        chk("idle_bwc", BWC, 32'hFFFF_FFFF);
        chk("idle_ac_hold", {27'd0, AC}, 32'd5);
        chk("idle_dc_hold", DC, 32'hDEAD_BEEF);

        // partial mask
        push1(5'd7, 32'h1234_5678, 32'hFFFF_FFFF);
        tick();
        tick();
        chk("pm_pre", prf[7], 32'h1234_5678);
        push1(5'd7, 32'hFFFF_FFFF, 32'h0000_FF00);
        tick();
        chk("pm_bwc", BWC, 32'hFFFF_00FF);
        tick();
        chk("pm_prf", prf[7], 32'h1234_FF78);

        // continuous stream: one in, one out per cycle
        REQ_VALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            REQ_ADDR = 5'(10 + i);
            REQ_DATA = 32'hA000_0000 + 32'(i);
            REQ_MASK = 32'hFFFF_FFFF;
            chk($sformatf("str_rdy%0d", i), {31'd0, REQ_READY}, 32'd1);
            tick();
            chk($sformatf("str_pend%0d", i), {29'd0, PENDING}, 32'd1);
            if (i > 0) begin
                chk($sformatf("str_wec%0d", i), {31'd0, WEC}, 32'd0);
                chk($sformatf("str_ac%0d", i), {27'd0, AC}, 32'(9 + i));
                chk($sformatf("str_dc%0d", i), DC, 32'hA000_0000 + 32'(i - 1));
            end
        end
        REQ_VALID = 1'b0;
        tick();
        chk("str_ac_last", {27'd0, AC}, 32'd15);
        chk("str_dc_last", DC, 32'hA000_0005);
        chk("str_pend_last", {29'd0, PENDING}, 32'd0);
        tick();
        chk("str_wec_end", {31'd0, WEC}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("str_prf%0d", i), prf[10 + i], 32'hA000_0000 + 32'(i));
        end

        // same address twice: last accepted wins
        REQ_VALID = 1'b1;
        REQ_ADDR  = 5'd3;
        REQ_MASK  = 32'hFFFF_FFFF;
        REQ_DATA  = 32'h0000_0111;
        tick();
        REQ_DATA  = 32'h0000_0222;
        tick();
        REQ_VALID = 1'b0;
        tick();
        tick();
        chk("waw_prf", prf[3], 32'h0000_0222);

        // zero mask: consumed, no write
        old = prf[20];
        push1(5'd20, 32'h0000_0055, 32'd0);
        chk("m0_pend1", {29'd0, PENDING}, 32'd1);
        tick();
        chk("m0_wec", {31'd0, WEC}, 32'd1);
        chk("m0_pend0", {29'd0, PENDING}, 32'd0);
        chk("m0_ac", {27'd0, AC}, 32'd20);
        chk("m0_bwc", BWC, 32'hFFFF_FFFF);
        chk("m0_dc", DC, 32'h0000_0055);
        tick();
        chk("m0_prf", prf[20], old);

        // reset with FIFO occupied
        push1(5'd9, 32'h0000_0077, 32'hFFFF_FFFF);
        chk("occ_pend", {29'd0, PENDING}, 32'd1);
        RESETN = 1'b0;
        #1;
        chk_reset_vals("occ_rst");

`ifdef PRF_WSEQ_INIT_SWEEP_EN
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (18) tick();
        chk("mid_ac17", {27'd0, AC}, 32'd17);
        chk("mid_wec", {31'd0, WEC}, 32'd0);
        #2;
        RESETN = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        run_init();
        chk("resweep_prf5", prf[5], 32'd0);
        chk("resweep_prf17", prf[17], 32'd0);
`else
        run_init();
`endif
        tick();
        chk("final_wec", {31'd0, WEC}, 32'd1);
        chk("final_pend", {29'd0, PENDING}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
